// File: rtl/code_pkg.sv
// Shared definitions for the code fetch front-end and the execute stage:
// FSM state encoding, instruction-word field positions and opcode constants.
package code_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    // The argument count lives in the two most significant bits of a command word.
    localparam int NARGS_W = 2;

    // Opcode field occupies the low byte of the command word.
    localparam int          OPC_W         = 8;
    localparam logic [7:0]  OPC_HLT       = 8'h00;
    localparam logic [1:0]  NARGS_ILLEGAL = 2'd3;

    // Bit position of the top of the nargs field for a given word width.
    function automatic int nargs_hi(input int word_size);
        return word_size - 1;
    endfunction

    // Bit position of the bottom of the nargs field for a given word width.
    function automatic int nargs_lo(input int word_size);
        return word_size - NARGS_W;
    endfunction

endpackage

// File: rtl/cmd_len_decode.sv
// Combinational command decoder: instruction length, HLT detection and
// illegal-encoding flag. Shared between fetch and execute.
module cmd_len_decode
    import code_pkg::*;
#(
    parameter int WORD_SIZE_ = 32
) (
    input  logic [WORD_SIZE_-1:0] cmd,
    output logic [1:0]            len,
    output logic                  is_hlt,
    output logic                  illegal
);

    localparam int NHI = nargs_hi(WORD_SIZE_);
    localparam int NLO = nargs_lo(WORD_SIZE_);

    logic [1:0] nargs;
    logic       unused_mid_bits;

    assign nargs = cmd[NHI:NLO];

    // Middle bits carry operand-specific payload that length decode ignores.
    assign unused_mid_bits = ^cmd[NLO-1:OPC_W];

    // Decode length and special encodings from the header fields.
    always_comb begin
        len     = nargs + 2'd1;
        illegal = (nargs == NARGS_ILLEGAL);
        is_hlt  = (nargs == 2'd0) && (cmd[OPC_W-1:0] == OPC_HLT);
    end

endmodule

// File: rtl/code_fetcher.sv
// Instruction fetch front-end. Holds the PC, reads a 3-word bundle from the
// code ROM, decodes the length and hands {cmd,args} to the execute stage over
// valid/ready. Supports jump redirects; stops for good on HLT or a bad fetch.
module code_fetcher
    import code_pkg::*;
#(
    parameter int WORD_SIZE_  = 32,
    parameter int ADDR_SIZE_  = 32,
    parameter int CODE_WORDS_ = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic [ADDR_SIZE_-1:0]   mem_addr,
    input  logic [3*WORD_SIZE_-1:0] mem_value,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_SIZE_-1:0]   out_cmd,
    output logic [WORD_SIZE_-1:0]   out_arg0,
    output logic [WORD_SIZE_-1:0]   out_arg1,
    output logic [ADDR_SIZE_-1:0]   out_pc,
    output logic [1:0]              out_len,
    input  logic                    jmp_valid,
    input  logic [ADDR_SIZE_-1:0]   jmp_addr,
    output logic                    halted,
    output logic                    fault
);

    // One extra bit keeps pc+len from wrapping past the top of the address space.
    localparam int AW1 = ADDR_SIZE_ + 1;
    localparam logic [AW1-1:0] CODE_END = AW1'(CODE_WORDS_);

    fetch_state_t state, state_next;

    logic [ADDR_SIZE_-1:0] pc, pc_next;
    logic [WORD_SIZE_-1:0] rom_cmd, rom_arg0, rom_arg1;
    logic [1:0]            dec_len;
    logic                  dec_hlt, dec_illegal;
    logic [AW1-1:0]        pc_ext, end_ext;
    logic                  load_bundle, clear_valid;
    logic                  bundle_hlt;

    assign rom_cmd  = mem_value[WORD_SIZE_-1:0];
    assign rom_arg0 = mem_value[2*WORD_SIZE_-1:WORD_SIZE_];
    assign rom_arg1 = mem_value[3*WORD_SIZE_-1:2*WORD_SIZE_];

    assign mem_addr = pc;
    assign pc_ext   = {1'b0, pc};
    assign end_ext  = pc_ext + AW1'(dec_len);

    assign halted = (state == HALT);
    assign fault  = (state == FAULT);

    cmd_len_decode #(
        .WORD_SIZE_(WORD_SIZE_)
    ) u_decode (
        .cmd    (rom_cmd),
        .len    (dec_len),
        .is_hlt (dec_hlt),
        .illegal(dec_illegal)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, next-PC and bundle control; jumps pre-empt everything while running.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        load_bundle = 1'b0;
        clear_valid = 1'b0;
        case (state)
            FETCH: begin
                if (jmp_valid) begin
                    pc_next = jmp_addr;
                end else if (pc_ext >= CODE_END) begin
                    state_next = FAULT;
                end else if (dec_illegal) begin
                    state_next = FAULT;
                end else if (end_ext > CODE_END) begin
                    state_next = FAULT;
                end else begin
                    load_bundle = 1'b1;
                    state_next  = ISSUE;
                end
            end
            ISSUE: begin
                if (jmp_valid) begin
                    pc_next     = jmp_addr;
                    clear_valid = 1'b1;
                    state_next  = FETCH;
                end else if (out_ready) begin
                    clear_valid = 1'b1;
                    if (bundle_hlt) begin
                        state_next = HALT;
                    end else begin
                        pc_next    = pc + ADDR_SIZE_'(out_len);
                        state_next = FETCH;
                    end
                end
            end
            HALT:    state_next = HALT;
            FAULT:   state_next = FAULT;
            default: state_next = FAULT;
        endcase
    end

    // PC and output bundle registers; unused argument slots are zeroed on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= '0;
            out_valid  <= 1'b0;
            out_cmd    <= '0;
            out_arg0   <= '0;
            out_arg1   <= '0;
            out_pc     <= '0;
            out_len    <= 2'd1;
            bundle_hlt <= 1'b0;
        end else begin
            pc <= pc_next;
            if (load_bundle) begin
                out_valid  <= 1'b1;
                out_cmd    <= rom_cmd;
                out_arg0   <= (dec_len >= 2'd2) ? rom_arg0 : '0;
                out_arg1   <= (dec_len == 2'd3) ? rom_arg1 : '0;
                out_pc     <= pc;
                out_len    <= dec_len;
                bundle_hlt <= dec_hlt;
            end else if (clear_valid) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_code_fetcher.sv
// Scoreboard bench for code_fetcher: an instruction-level model predicts each
// presented bundle and the per-cycle status; two monitors compare.
module tb_code_fetcher;

    localparam int W  = 32;
    localparam int NW = 64;

    typedef struct packed {
        logic [31:0] cmd;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] pc;
        logic [1:0]  len;
    } bundle_t;

    typedef struct packed {
        logic        v;
        logic        h;
        logic        f;
        logic [31:0] a;
    } stat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   mem_addr;
    logic [95:0]   mem_value;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_cmd, out_arg0, out_arg1, out_pc;
    logic [1:0]    out_len;
    logic          jmp_valid = 1'b0;
    logic [31:0]   jmp_addr = '0;
    logic          halted, fault;

    logic [31:0]   rom [NW];
    bundle_t       bq[$];
    stat_t         sq[$];
    bit            chk_en = 1'b0;
    int            checks = 0;
    int            errors = 0;

    logic [31:0]   m_addr;
    bit            m_pres;
    int            m_end;   // 0 running, 1 halted, 2 faulted

    code_fetcher #(.WORD_SIZE_(W), .ADDR_SIZE_(32), .CODE_WORDS_(NW)) dut (
        .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_value(mem_value),
        .out_valid(out_valid), .out_ready(out_ready), .out_cmd(out_cmd),
        .out_arg0(out_arg0), .out_arg1(out_arg1), .out_pc(out_pc), .out_len(out_len),
        .jmp_valid(jmp_valid), .jmp_addr(jmp_addr), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    always_comb begin
        mem_value = '0;
        if (mem_addr < 32'(NW))     mem_value[31:0]  = rom[mem_addr[5:0]];
        if (mem_addr < 32'(NW - 1)) mem_value[63:32] = rom[mem_addr[5:0] + 6'd1];
        if (mem_addr < 32'(NW - 2)) mem_value[95:64] = rom[mem_addr[5:0] + 6'd2];
    end

    // Instruction-level view of the code segment at address a.
    function automatic void model_fetch(input logic [31:0] a, output bit bad,
                                        output bit hlt, output bundle_t b);
        int n;
        int ai;
        b   = '0;
        bad = 1'b0;
        hlt = 1'b0;
        if (a >= 32'(NW)) begin
            bad = 1'b1;
            return;
        end
        ai    = int'(a);
        b.cmd = rom[ai];
        n     = int'(b.cmd[31:30]);
        if (n == 3 || ai + n + 1 > NW) begin
            bad = 1'b1;
            return;
        end
        b.len = 2'(n + 1);
        b.pc  = a;
        if (n >= 1) b.a0 = rom[ai + 1];
        if (n >= 2) b.a1 = rom[ai + 2];
        hlt = (n == 0) && (b.cmd[7:0] == 8'h00);
    endfunction

    // Drive one cycle of stimulus and push what the DUT must show.
    task automatic step(input bit rdy, input bit jv, input logic [31:0] ja);
        bundle_t b;
        bit      bad, hlt;
        stat_t   s;
        out_ready = rdy;
        jmp_valid = jv;
        jmp_addr  = ja;
        if (m_end == 0) begin
            model_fetch(m_addr, bad, hlt, b);
            if (m_pres) begin
                bq.push_back(b);
                if (jv) begin
                    m_addr = ja;
                    m_pres = 1'b0;
                end else if (rdy) begin
                    m_pres = 1'b0;
                    if (hlt) m_end = 1;
                    else     m_addr = m_addr + 32'(b.len);
                end
            end else begin
                if (jv)       m_addr = ja;
                else if (bad) m_end = 2;
                else          m_pres = 1'b1;
            end
        end
        s.v = m_pres;
        s.h = (m_end == 1);
        s.f = (m_end == 2);
        s.a = m_addr;
        sq.push_back(s);
        @(posedge clk);
        #2;
    endtask

    task automatic step_rand();
        step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 32'($urandom_range(0, 66)));
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        chk_en    = 1'b0;
        out_ready = 1'b0;
        jmp_valid = 1'b0;
        jmp_addr  = '0;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_cmd !== '0 || out_arg0 !== '0 || out_arg1 !== '0 ||
            out_pc !== '0 || out_len !== 2'd1 || halted !== 1'b0 || fault !== 1'b0 ||
            mem_addr !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%0b cmd=%h a0=%h a1=%h pc=%0d len=%0d h=%0b f=%0b addr=%0d, want all zero with len=1",
                     out_valid, out_cmd, out_arg0, out_arg1, out_pc, out_len, halted, fault, mem_addr);
        end
        bq.delete();
        sq.delete();
        m_addr = '0;
        m_pres = 1'b0;
        m_end  = 0;
        @(posedge clk);
        #2;
        rst_n  = 1'b1;
        chk_en = 1'b1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < NW; i++) rom[i] = '0;
    endtask

    task automatic random_rom();
        for (int i = 0; i < NW; i++) begin
            logic [31:0] w;
            int r;
            r = $urandom_range(0, 15);
            w = $urandom;
            if (r == 0) begin
                w = '0;
            end else if (r == 1) begin
                w[31:30] = 2'b11;
            end else begin
                w[31:30] = 2'($urandom_range(0, 2));
                if (w[7:0] == 8'h00) w[0] = 1'b1;
            end
            rom[i] = w;
        end
    endtask

    // Status monitor: state visible just after each edge.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            stat_t e;
            checks++;
            if (sq.size() == 0) begin
                errors++;
                $display("FAIL status_queue: no expectation queued at t=%0t", $time);
            end else begin
                e = sq.pop_front();
                if (out_valid !== e.v || halted !== e.h || fault !== e.f || mem_addr !== e.a) begin
                    errors++;
                    $display("FAIL status: got v=%0b h=%0b f=%0b addr=%0d, want v=%0b h=%0b f=%0b addr=%0d at t=%0t",
                             out_valid, halted, fault, mem_addr, e.v, e.h, e.f, e.a, $time);
                end
            end
        end
    end

    // Bundle monitor: every presented bundle is compared while it is offered.
    always @(negedge clk) begin
        if (chk_en) begin
            bundle_t e;
            if (bq.size() > 0) begin
                e = bq.pop_front();
                checks++;
                if (out_valid !== 1'b1 || out_cmd !== e.cmd || out_arg0 !== e.a0 ||
                    out_arg1 !== e.a1 || out_pc !== e.pc || out_len !== e.len) begin
                    errors++;
                    $display("FAIL bundle: got v=%0b pc=%0d cmd=%h a0=%h a1=%h len=%0d, want v=1 pc=%0d cmd=%h a0=%h a1=%h len=%0d",
                             out_valid, out_pc, out_cmd, out_arg0, out_arg1, out_len,
                             e.pc, e.cmd, e.a0, e.a1, e.len);
                end
            end else if (out_valid === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: bundle pc=%0d cmd=%h offered, want none", out_pc, out_cmd);
            end
        end
    end

    initial begin
        clear_rom();
        repeat (2) @(posedge clk);
        #2;

        // Two-instruction program ending in HLT.
        rom[0] = 32'h40000005;
        rom[1] = 32'h00000011;
        do_reset();
        repeat (8) step(1'b1, 1'b0, '0);

        // Back-pressure on the first bundle.
        do_reset();
        step(1'b0, 1'b0, '0);
        repeat (5) step(1'b0, 1'b0, '0);
        repeat (6) step(1'b1, 1'b0, '0);

        // Illegal nargs at address 0; later jumps ignored.
        clear_rom();
        rom[0] = 32'hC0000001;
        do_reset();
        step(1'b1, 1'b0, '0);
        repeat (3) step(1'b1, 1'b1, 32'd5);

        // Length running past the end of the segment, and an out-of-range target.
        clear_rom();
        rom[63] = 32'h80000007;
        do_reset();
        step(1'b1, 1'b1, 32'd63);
        repeat (3) step(1'b1, 1'b0, '0);
        do_reset();
        step(1'b1, 1'b1, 32'd64);
        repeat (3) step(1'b1, 1'b1, 32'd0);

        // Jump together with a handshake, then a jump that drops a stalled bundle.
        clear_rom();
        rom[0]  = 32'h40000005;
        rom[1]  = 32'h00000011;
        rom[10] = 32'h80000033;
        rom[11] = 32'h00000001;
        rom[12] = 32'h00000002;
        rom[20] = 32'h00000042;
        do_reset();
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 32'd10);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 32'd20);
        repeat (6) step(1'b1, 1'b0, '0);

        // Reset while a bundle is being offered.
        do_reset();
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        do_reset();
        repeat (5) step(1'b1, 1'b0, '0);

        // Randomized programs, back-pressure and redirects.
        for (int ep = 0; ep < 25; ep++) begin
            random_rom();
            do_reset();
            repeat (40) step_rand();
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
